// File: rtl/pattern_recorder.sv
// Records LED patterns composed with four debounced pushbuttons and commits them
// to consecutive addresses of the pattern RAM write port; clear sweeps the RAM to zero.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | editing; accepts cursor/toggle/commit/clear presses
// S_WRITE | single-cycle RAM write of the committed pattern
// S_CLEAR | sweeps every RAM address with zero, then resets the recorder
module pattern_recorder #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 6,
    parameter int CUR_W  = 4
) (
    input  logic              CLK_50,
    input  logic              reset_n,
    input  logic              pb_cursor,
    input  logic              pb_toggle,
    input  logic              pb_commit,
    input  logic              pb_clear,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic [DATA_W-1:0] edit_pattern,
    output logic [CUR_W-1:0]  cursor,
    output logic [ADDR_W:0]   length,
    output logic              full,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        pb_level;
    logic [3:0]        pb_prev;
    logic [3:0]        press;
    logic              commit_go;
    logic              sweep_last;
    logic [DATA_W-1:0] toggle_mask;
    logic [CUR_W-1:0]  cursor_inc;

    // Bit order everywhere: {clear, commit, toggle, cursor}
    assign pb_level    = {pb_clear, pb_commit, pb_toggle, pb_cursor};
    assign press       = pb_prev & ~pb_level;
    assign commit_go   = press[2] & ~full;
    assign sweep_last  = (wr_addr == ADDR_W'(DEPTH - 1));
    assign toggle_mask = {{(DATA_W-1){1'b0}}, 1'b1} << cursor;
    assign cursor_inc  = (cursor == CUR_W'(DATA_W - 1)) ? '0 : cursor + CUR_W'(1);

    assign full  = (length == (ADDR_W+1)'(DEPTH));
    assign busy  = (state != S_IDLE);
    assign wr_en = (state != S_IDLE);

    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (press[3]) begin
                    state_nxt = S_CLEAR;
                end else if (commit_go) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: state_nxt = S_IDLE;
            S_CLEAR: begin
                if (sweep_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Presses arriving while busy still update pb_prev but are otherwise dropped.
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            pb_prev      <= 4'hF;
            cursor       <= '0;
            edit_pattern <= '0;
            length       <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            pb_prev <= pb_level;
            case (state)
                S_IDLE: begin
                    if (press[3]) begin
                        wr_addr <= '0;
                        wr_data <= '0;
                    end else if (commit_go) begin
                        wr_addr <= length[ADDR_W-1:0];
                        wr_data <= edit_pattern;
                    end else begin
                        if (press[1]) begin
                            edit_pattern <= edit_pattern ^ toggle_mask;
                        end
                        if (press[0]) begin
                            cursor <= cursor_inc;
                        end
                    end
                end
                S_WRITE: begin
                    length <= length + (ADDR_W+1)'(1);
                end
                S_CLEAR: begin
                    if (sweep_last) begin
                        length       <= '0;
                        cursor       <= '0;
                        edit_pattern <= '0;
                    end else begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_recorder.sv
// Bench for pattern_recorder: directed scenarios plus random button activity,
// every cycle compared against a transaction-level model of the recorder.
module tb_pattern_recorder;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 6;
    localparam int CUR_W  = 4;
    localparam int DEPTH  = 64;

    logic              CLK_50 = 1'b0;
    logic              reset_n = 1'b0;
    logic              pb_cursor = 1'b1;
    logic              pb_toggle = 1'b1;
    logic              pb_commit = 1'b1;
    logic              pb_clear = 1'b1;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [DATA_W-1:0] edit_pattern;
    logic [CUR_W-1:0]  cursor;
    logic [ADDR_W:0]   length;
    logic              full;
    logic              busy;

    pattern_recorder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CUR_W(CUR_W)) dut (
        .CLK_50      (CLK_50),
        .reset_n     (reset_n),
        .pb_cursor   (pb_cursor),
        .pb_toggle   (pb_toggle),
        .pb_commit   (pb_commit),
        .pb_clear    (pb_clear),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .edit_pattern(edit_pattern),
        .cursor      (cursor),
        .length      (length),
        .full        (full),
        .busy        (busy)
    );

    always #10 CLK_50 = ~CLK_50;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM image as written by the DUT, plus a log of individual writes
    typedef struct {int addr; int data;} wr_t;
    wr_t         wlog[$];
    logic [DATA_W-1:0] d_ram [DEPTH];
    logic [DATA_W-1:0] m_ram [DEPTH];

    always @(posedge CLK_50) begin
        if (wr_en === 1'b1) begin
            d_ram[wr_addr] <= wr_data;
            wlog.push_back('{addr: int'(wr_addr), data: int'(wr_data)});
        end
    end

    // Reference model: button edges, pending-write countdown, plain arithmetic
    logic [3:0]        m_prev;
    int                m_cursor, m_length, m_left, m_addr;
    logic [DATA_W-1:0] m_pattern, m_data;
    bit                m_clr_mode;

    task automatic model_reset();
        m_prev = 4'hF; m_cursor = 0; m_length = 0; m_left = 0;
        m_addr = 0; m_data = '0; m_pattern = '0; m_clr_mode = 0;
    endtask

    task automatic model_edge(input logic [3:0] lvl);
        logic [3:0] pr;
        pr = m_prev & ~lvl;
        m_prev = lvl;
        if (m_left > 0) begin
            m_ram[m_addr] = m_data;
            m_left--;
            if (!m_clr_mode) m_length++;
            else if (m_left == 0) begin
                m_length = 0; m_cursor = 0; m_pattern = '0;
            end else m_addr++;
        end else if (pr[3]) begin
            m_clr_mode = 1; m_left = DEPTH; m_addr = 0; m_data = '0;
        end else if (pr[2] && m_length < DEPTH) begin
            m_clr_mode = 0; m_left = 1; m_addr = m_length % DEPTH; m_data = m_pattern;
        end else begin
            if (pr[1]) m_pattern[m_cursor] = ~m_pattern[m_cursor];
            if (pr[0]) m_cursor = (m_cursor + 1) % DATA_W;
        end
    endtask

    string phase = "reset";

    task automatic check_outputs();
        chk({phase, "/cursor"},  32'(cursor),       32'(m_cursor));
        chk({phase, "/pattern"}, 32'(edit_pattern), 32'(m_pattern));
        chk({phase, "/length"},  32'(length),       32'(m_length));
        chk({phase, "/full"},    32'(full),         32'(m_length == DEPTH));
        chk({phase, "/busy"},    32'(busy),         32'(m_left > 0));
        chk({phase, "/wr_en"},   32'(wr_en),        32'(m_left > 0));
        chk({phase, "/wr_addr"}, 32'(wr_addr),      32'(m_addr));
        chk({phase, "/wr_data"}, 32'(wr_data),      32'(m_data));
    endtask

    // lvl bits are active-low levels {clear, commit, toggle, cursor}
    task automatic step(input logic [3:0] lvl);
        {pb_clear, pb_commit, pb_toggle, pb_cursor} = lvl;
        @(posedge CLK_50);
        model_edge(lvl);
        #1;
        check_outputs();
    endtask

    task automatic press(input logic [3:0] mask);
        step(~mask);
        step(4'hF);
    endtask

    task automatic ram_compare(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (d_ram[i] !== m_ram[i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] target;
        logic [3:0]        lvl;
        int                bad;
        for (int i = 0; i < DEPTH; i++) begin
            d_ram[i] = '0;
            m_ram[i] = '0;
        end
        model_reset();

        reset_n = 1'b0;
        repeat (3) @(posedge CLK_50);
        #1;
        check_outputs();
        @(negedge CLK_50);
        reset_n = 1'b1;
        phase = "post_reset";
        repeat (3) step(4'hF);

        phase = "edit";
        repeat (3) press(4'b0001);
        press(4'b0010);
        repeat (7) press(4'b0001);
        press(4'b0010);
        chk("edit_pattern_const", 32'(edit_pattern), 32'h009);
        chk("edit_cursor_wrap",   32'(cursor),       32'd0);

        phase = "hold";
        repeat (5) step(~4'b0001);
        step(4'hF);
        chk("hold_one_press", 32'(cursor), 32'd1);
        repeat (9) press(4'b0001);

        phase = "compose";
        target = 10'h2A5;
        for (int i = 0; i < DATA_W; i++) begin
            if (m_pattern[m_cursor] != target[m_cursor]) press(4'b0010);
            press(4'b0001);
        end
        chk("compose_2a5", 32'(edit_pattern), 32'h2A5);

        phase = "commit";
        wlog.delete();
        press(4'b0100);
        press(4'b0100);
        chk("commit_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("commit0_addr", 32'(wlog[0].addr), 32'd0);
            chk("commit0_data", 32'(wlog[0].data), 32'h2A5);
            chk("commit1_addr", 32'(wlog[1].addr), 32'd1);
            chk("commit1_data", 32'(wlog[1].data), 32'h2A5);
        end
        chk("commit_length", 32'(length), 32'd2);

        phase = "fill";
        repeat (62) press(4'b0100);
        chk("full_set",    32'(full),   32'd1);
        chk("full_length", 32'(length), 32'd64);
        wlog.delete();
        press(4'b0100);
        chk("full_no_write", 32'(wlog.size()), 32'd0);
        chk("full_hold_len", 32'(length),      32'd64);
        ram_compare("ram_after_fill");

        phase = "clear";
        wlog.delete();
        step(~4'b1011);
        for (int c = 0; c < 70; c++) step(c == 10 ? ~4'b0100 : 4'hF);
        chk("clear_write_count", 32'(wlog.size()), 32'd64);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i].addr != i || wlog[i].data != 0) bad++;
        chk("clear_sweep", 32'(bad), 32'd0);
        chk("clear_length",  32'(length),       32'd0);
        chk("clear_cursor",  32'(cursor),       32'd0);
        chk("clear_pattern", 32'(edit_pattern), 32'd0);

        phase = "random";
        for (int c = 0; c < 1500; c++) begin
            lvl[0] = ($urandom_range(0, 9) >= 3);
            lvl[1] = ($urandom_range(0, 9) >= 3);
            lvl[2] = ($urandom_range(0, 9) >= 3);
            lvl[3] = ($urandom_range(0, 39) != 0);
            step(lvl);
        end
        repeat (70) step(4'hF);
        ram_compare("ram_after_random");

        phase = "reset_mid_clear";
        press(4'b0100);
        step(~4'b1000);
        repeat (19) step(4'hF);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_wr_en", 32'(wr_en),  32'd0);
        chk("async_busy",  32'(busy),   32'd0);
        chk("async_len",   32'(length), 32'd0);
        model_reset();
        repeat (2) @(posedge CLK_50);
        @(negedge CLK_50);
        reset_n = 1'b1;
        repeat (5) step(4'hF);
        chk("after_abort_length", 32'(length), 32'd0);
        ram_compare("ram_partial_erase");
        press(4'b0100);
        ram_compare("ram_after_abort_commit");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_recorder.md
# pattern_recorder

Pattern recorder: the write-side counterpart of the sequencer's playback path. It lets the user compose 10-bit LED patterns bit by bit with the four debounced pushbuttons and commits each finished pattern into the write port of the dual-port pattern RAM at consecutive addresses. The sequencer then plays the stored sequence back through the RAM read port on `slow_clk`. The block runs entirely on `CLK_50` and also provides a live preview of the pattern being edited.

## Interface
Parameters:
- `DATA_W`, default 10: pattern width; equals LED count and RAM word width.
- `ADDR_W`, default 6: RAM address width; depth = 2^ADDR_W patterns.
- `CUR_W`, default 4: cursor width; must satisfy 2^CUR_W >= DATA_W.

Ports (name, direction, width, meaning):
- `CLK_50`  in  1  system clock; also the RAM write clock.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `pb_cursor`  in  1  debounced button, active-low level, synchronous to `CLK_50`; a press advances the cursor.
- `pb_toggle`  in  1  debounced button, active-low; a press inverts the pattern bit at the cursor.
- `pb_commit`  in  1  debounced button, active-low; a press writes the pattern to RAM.
- `pb_clear`  in  1  debounced button, active-low; a press erases the RAM and resets the recorder.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wr_data`  out  DATA_W  RAM write data.
- `wr_en`  out  1  RAM write enable.
- `edit_pattern`  out  DATA_W  pattern under edit, for the preview.
- `cursor`  out  CUR_W  currently selected bit index.
- `length`  out  ADDR_W+1  number of patterns stored.
- `full`  out  1  high when `length == 2^ADDR_W`.
- `busy`  out  1  high in the WRITE or CLEAR state.

## Operation
- **Press detection:** each button has a registered previous level, reset to 1 (released). A press is a 1→0 transition at a sampling edge. Holding a button produces exactly one press. Releasing a button has no effect.
- **FSM states:** IDLE, WRITE, CLEAR. The reset state is IDLE.
- **IDLE, cursor press:** `cursor` increments. At DATA_W-1 it wraps to 0.
- **IDLE, toggle press:** `edit_pattern[cursor] ^= 1`, using the cursor value before any same-cycle increment.
- **IDLE, commit press with `full`=0:**
  - Go to WRITE.
  - Load `wr_addr = length[ADDR_W-1:0]` and `wr_data = edit_pattern`.
  - `edit_pattern` and `cursor` are kept, so the next pattern starts from a copy of this one.
- **IDLE, commit press with `full`=1:** ignored; no write and no state change.
- **IDLE, clear press:** go to CLEAR and set the sweep address to 0.
- **WRITE:** `wr_en` is high for this single cycle. `length` increments on leaving WRITE. Next state is IDLE.
- **CLEAR:**
  - `wr_en` is high and `wr_data` is 0 for 2^ADDR_W consecutive cycles, with `wr_addr` = 0, 1, …, 2^ADDR_W-1.
  - After the last address: `length`, `cursor` and `edit_pattern` are set to 0 and the state returns to IDLE.
- **Simultaneous presses in IDLE:** priority is clear > commit > {toggle, cursor}.
  - Toggle and cursor presses in the same cycle are both applied.
  - When clear or commit wins, any same-cycle toggle or cursor press is dropped.
- **Presses while `busy`=1:** still detected (the edge registers keep tracking) but discarded, never queued.
- **Width rules:**
  - `length` saturates at 2^ADDR_W and never wraps.
  - `wr_addr` is the low ADDR_W bits of `length`.
  - `cursor` never exceeds DATA_W-1.
- **Outputs at reset:** every output is 0, including `full` and `busy`. When `wr_en` is low, `wr_addr` and `wr_data` hold their last values.
- **Reset mid-operation:** `reset_n` low forces IDLE immediately and drops `wr_en` asynchronously.
  - If this aborts a CLEAR, the RAM is left partially erased; `length` is 0 after reset, so the sequencer ignores the stale content.

## Timing
- All state and outputs are registered on rising `CLK_50`. There is no combinational path from any button input to any output.
- **Edit latency:** a press sampled at edge n is visible on `cursor` / `edit_pattern` after edge n (1 cycle).
- **Commit timing:**
  - Press sampled at edge n: `wr_en`=1 with address and data valid during cycle n..n+1.
  - At edge n+1: `length` increments, `wr_en` falls, and `busy` returns to 0.
- **Clear timing:**
  - Press sampled at edge n: `busy`=1 from edge n to edge n+2^ADDR_W.
  - `wr_en` is high for exactly 2^ADDR_W cycles.
  - `length`=0 after edge n+2^ADDR_W.
- **Earliest next action:** one cycle after `busy` falls.
- **Write throughput:** at most one RAM write per cycle. The RAM samples `wr_addr` / `wr_data` / `wr_en` on the same `CLK_50` edge.

## Test plan
- **Reset:**
  - Stimulus: hold `reset_n`=0 with all buttons at 1, then release.
  - Required: all outputs are 0, the state is IDLE, and there is no spurious press after release.
- **Edit:**
  - Stimulus: cursor press ×3, toggle, cursor ×7, toggle.
  - Required: `edit_pattern` = 10'b0000001001 and `cursor` = 0 (wrapped).
- **Commit:**
  - Stimulus: set `edit_pattern` = 10'h2A5, then commit ×2.
  - Required: two single-cycle `wr_en` pulses, at addresses 0 and 1, both with data 10'h2A5; `length` = 2.
- **Full:**
  - Stimulus: perform 64 commits, then a 65th.
  - Required: `full`=1 after the 64th commit; the 65th produces no `wr_en` and `length` stays 64.
- **Clear plus simultaneity:**
  - Stimulus: clear, toggle and cursor pressed in the same cycle.
  - Required:
    - `wr_en` high for 64 cycles, addresses 0..63, data 0.
    - Toggle and cursor dropped.
    - Then `length`, `cursor` and `edit_pattern` are all 0.
    - A commit pressed during the CLEAR is ignored.
- **Reset mid-clear:**
  - Stimulus: assert `reset_n` at clear cycle 20.
  - Required: `wr_en` drops immediately (asynchronously), and after release the block is in IDLE with `length` = 0.
